// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one memory port between fetch (m0)
//            and load/store (m1), one transaction in flight, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic                  m0_we,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_resp_valid,
   output logic [DATA_WIDTH-1:0] m0_resp_rdata,
   output logic                  m0_resp_err,
   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic                  m1_we,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_resp_valid,
   output logic [DATA_WIDTH-1:0] m1_resp_rdata,
   output logic                  m1_resp_err,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
   output logic                  busy,
   output logic                  grant_id
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_last_grant;
   logic                  r_grant_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [15:0]           r_cnt;

   logic                  w_pick;
   logic                  w_accept;
   logic                  w_rsp_valid;
   logic                  w_rsp_err;
   logic [DATA_WIDTH-1:0] w_rsp_rdata;

   // Under contention the master that did not win last time is chosen.
   always_comb begin
      w_pick = (m0_req_valid & m1_req_valid) ? ~r_last_grant : m1_req_valid;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      w_rsp_valid   = 1'b0;
      w_rsp_err     = 1'b0;
      w_rsp_rdata   = '0;
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      mem_req_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Readies are combinational, so hold them low while reset is applied.
            if (rst_n && (m0_req_valid || m1_req_valid)) begin
               w_accept     = 1'b1;
               m0_req_ready = ~w_pick;
               m1_req_ready = w_pick;
               w_state_nxt  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A real response beats a coincident timeout.
            if (mem_resp_valid) begin
               w_rsp_valid = 1'b1;
               w_rsp_rdata = r_we ? '0 : mem_resp_rdata;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == c_timeout_last) begin
               w_rsp_valid = 1'b1;
               w_rsp_err   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_cnt        <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_grant_id <= w_pick;
            r_addr     <= w_pick ? m1_addr  : m0_addr;
            r_we       <= w_pick ? m1_we    : m0_we;
            r_wdata    <= w_pick ? m1_wdata : m0_wdata;
         end
         if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_rsp_valid) begin
            r_last_grant <= r_grant_id;
         end
      end
   end

   assign m0_resp_valid = w_rsp_valid & ~r_grant_id;
   assign m1_resp_valid = w_rsp_valid &  r_grant_id;
   assign m0_resp_err   = w_rsp_err   & ~r_grant_id;
   assign m1_resp_err   = w_rsp_err   &  r_grant_id;
   assign m0_resp_rdata = r_grant_id ? '0 : w_rsp_rdata;
   assign m1_resp_rdata = r_grant_id ? w_rsp_rdata : '0;

   assign mem_addr  = r_addr;
   assign mem_we    = r_we;
   assign mem_wdata = r_wdata;
   assign busy      = (r_state != ST_IDLE);
   assign grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Vector tables, directed corner sequences and random traffic
//            checked against a transaction-level model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int c_to = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
   logic        m0_req_ready, m1_req_ready;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_resp_valid, m1_resp_valid;
   logic [31:0] m0_resp_rdata, m1_resp_rdata;
   logic        m0_resp_err, m1_resp_err;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_rdata = '0;
   logic        busy, grant_id;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(c_to)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
      .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_resp_valid(m0_resp_valid),
      .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
      .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_resp_valid(m1_resp_valid),
      .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata), .busy(busy), .grant_id(grant_id)
   );

   typedef struct {
      logic        m0v, m1v;
      logic [31:0] a0, a1;
      logic        we0, we1;
      logic [31:0] wd;
      logic        mrdy, mresp;
      logic [31:0] mrd;
      bit          chk;
      logic        r0, r1, mv;
      logic [31:0] maddr;
      logic        mwe, v0, v1, err;
      logic [31:0] rd;
      logic        busy;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   vec_t tbl[$];

   // Transaction-level model: one pending transaction with its owner and age.
   bit          mb_busy, mb_issued, mb_last, mb_gid, mb_we;
   int          mb_waited;
   logic [31:0] mb_addr, mb_wdata;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t vi(input int m0v, input int m1v, input logic [31:0] a0,
                               input logic [31:0] a1, input int we0, input int we1,
                               input logic [31:0] wd, input int mrdy, input int mresp,
                               input logic [31:0] mrd);
      vec_t v;
      v = '{default: '0};
      v.m0v = (m0v != 0); v.m1v = (m1v != 0); v.a0 = a0; v.a1 = a1;
      v.we0 = (we0 != 0); v.we1 = (we1 != 0); v.wd = wd;
      v.mrdy = (mrdy != 0); v.mresp = (mresp != 0); v.mrd = mrd;
      return v;
   endfunction

   function automatic vec_t ve(input vec_t vin, input int r0, input int r1, input int mv,
                               input logic [31:0] maddr, input int mwe, input int v0,
                               input int v1, input int err, input logic [31:0] rd,
                               input int bsy);
      vec_t v;
      v = vin;
      v.chk = 1'b1;
      v.r0 = (r0 != 0); v.r1 = (r1 != 0); v.mv = (mv != 0); v.maddr = maddr;
      v.mwe = (mwe != 0); v.v0 = (v0 != 0); v.v1 = (v1 != 0); v.err = (err != 0);
      v.rd = rd; v.busy = (bsy != 0);
      return v;
   endfunction

   function automatic vec_t idle_v();
      return vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic model_reset();
      mb_busy = 0; mb_issued = 0; mb_last = 1; mb_gid = 0; mb_we = 0;
      mb_waited = 0; mb_addr = '0; mb_wdata = '0;
   endtask

   function automatic bit pick_of(input vec_t v);
      return (v.m0v && v.m1v) ? !mb_last : v.m1v;
   endfunction

   task automatic model_check(input vec_t v);
      bit          er0 = 0, er1 = 0, emv = 0, ev0 = 0, ev1 = 0, eerr = 0;
      logic [31:0] erd = '0;
      if (!mb_busy) begin
         if (v.m0v || v.m1v) begin
            er0 = !pick_of(v);
            er1 = pick_of(v);
         end
      end else if (!mb_issued) begin
         emv = 1;
      end else if (v.mresp) begin
         ev0 = !mb_gid; ev1 = mb_gid;
         erd = mb_we ? 32'h0 : v.mrd;
      end else if (mb_waited + 1 == c_to) begin
         ev0 = !mb_gid; ev1 = mb_gid; eerr = 1;
      end
      chk1("m0_req_ready", m0_req_ready, er0);
      chk1("m1_req_ready", m1_req_ready, er1);
      chk1("mem_req_valid", mem_req_valid, emv);
      chk1("busy", busy, mb_busy);
      chk1("grant_id", grant_id, mb_gid);
      chk32("mem_addr", mem_addr, mb_addr);
      chk1("mem_we", mem_we, mb_we);
      chk32("mem_wdata", mem_wdata, mb_wdata);
      chk1("m0_resp_valid", m0_resp_valid, ev0);
      chk1("m1_resp_valid", m1_resp_valid, ev1);
      if (ev0) begin
         chk1("m0_resp_err", m0_resp_err, eerr);
         chk32("m0_resp_rdata", m0_resp_rdata, erd);
      end
      if (ev1) begin
         chk1("m1_resp_err", m1_resp_err, eerr);
         chk32("m1_resp_rdata", m1_resp_rdata, erd);
      end
   endtask

   task automatic model_update(input vec_t v);
      bit p;
      if (!mb_busy) begin
         if (v.m0v || v.m1v) begin
            p = pick_of(v);
            mb_busy = 1; mb_issued = 0; mb_gid = p;
            mb_addr  = p ? v.a1  : v.a0;
            mb_we    = p ? v.we1 : v.we0;
            mb_wdata = p ? ~v.wd : v.wd;
         end
      end else if (!mb_issued) begin
         if (v.mrdy) begin
            mb_issued = 1;
            mb_waited = 0;
         end
      end else begin
         mb_waited++;
         if (v.mresp || mb_waited == c_to) begin
            mb_busy = 0;
            mb_last = mb_gid;
         end
      end
   endtask

   // First half of a cycle: drive at posedge+1, compare at the falling edge.
   task automatic cyc_a(input vec_t v);
      m0_req_valid = v.m0v; m1_req_valid = v.m1v;
      m0_addr = v.a0; m1_addr = v.a1; m0_we = v.we0; m1_we = v.we1;
      m0_wdata = v.wd; m1_wdata = ~v.wd;
      mem_req_ready = v.mrdy; mem_resp_valid = v.mresp; mem_resp_rdata = v.mrd;
      #4;
      model_check(v);
      if (v.chk) begin
         chk1("tbl_m0_req_ready", m0_req_ready, v.r0);
         chk1("tbl_m1_req_ready", m1_req_ready, v.r1);
         chk1("tbl_mem_req_valid", mem_req_valid, v.mv);
         chk1("tbl_busy", busy, v.busy);
         chk1("tbl_m0_resp_valid", m0_resp_valid, v.v0);
         chk1("tbl_m1_resp_valid", m1_resp_valid, v.v1);
         if (v.mv) begin
            chk32("tbl_mem_addr", mem_addr, v.maddr);
            chk1("tbl_mem_we", mem_we, v.mwe);
         end
         if (v.v0) begin
            chk1("tbl_m0_resp_err", m0_resp_err, v.err);
            chk32("tbl_m0_resp_rdata", m0_resp_rdata, v.rd);
         end
         if (v.v1) begin
            chk1("tbl_m1_resp_err", m1_resp_err, v.err);
            chk32("tbl_m1_resp_rdata", m1_resp_rdata, v.rd);
         end
      end
   endtask

   task automatic cyc_b(input vec_t v);
      @(posedge clk);
      model_update(v);
      #1;
   endtask

   task automatic step(input vec_t v);
      cyc_a(v);
      cyc_b(v);
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
      tbl.delete();
   endtask

   task automatic do_reset();
      cyc_a(idle_v());
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_m0_req_ready"}, m0_req_ready, 1'b0);
      chk1({tag, "_m1_req_ready"}, m1_req_ready, 1'b0);
      chk1({tag, "_m0_resp_valid"}, m0_resp_valid, 1'b0);
      chk1({tag, "_m1_resp_valid"}, m1_resp_valid, 1'b0);
      chk1({tag, "_m0_resp_err"}, m0_resp_err, 1'b0);
      chk32({tag, "_m0_resp_rdata"}, m0_resp_rdata, 32'h0);
      chk32({tag, "_m1_resp_rdata"}, m1_resp_rdata, 32'h0);
      chk1({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_grant_id"}, grant_id, 1'b0);
      chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
   endtask

   initial begin
      vec_t v;
      int   g;
      logic [31:0] rd;

      model_reset();
      repeat (2) @(posedge clk);
      #5;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single m0 read with minimum latency.
      tbl.push_back(ve(vi(1, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF), 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 1));
      tbl.push_back(ve(idle_v(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run_table();

      // Continuous contention alternates m0, m1, m0, m1.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         g  = i % 2;
         rd = 32'hA000_0000 + 32'(i);
         v  = vi(1, 1, 32'h0, 32'h4, 0, 0, 0, 1, 1, rd);
         tbl.push_back(ve(v, 1 - g, g, 0, 0, 0, 0, 0, 0, 0, 0));
         tbl.push_back(ve(v, 0, 0, 1, (g == 1) ? 32'h4 : 32'h0, 0, 0, 0, 0, 0, 1));
         tbl.push_back(ve(v, 0, 0, 0, 0, 0, 1 - g, g, 0, rd, 1));
      end
      tbl.push_back(ve(idle_v(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run_table();

      // m1 write with memory back-pressure.
      tbl.push_back(ve(vi(0, 1, 0, 32'h20, 0, 1, 32'hEDCBA987, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(ve(idle_v(), 0, 0, 1, 32'h20, 1, 0, 0, 0, 0, 1));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 1, 32'h20, 1, 0, 0, 0, 0, 1));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF), 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(ve(idle_v(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run_table();

      // Spurious responses in IDLE and ISSUE are dropped.
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(ve(vi(1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 32'h77), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), 0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 1));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77), 0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 1));
      tbl.push_back(ve(idle_v(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(ve(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55), 0, 0, 0, 0, 0, 1, 0, 0, 32'h55, 1));
      tbl.push_back(ve(idle_v(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run_table();

      // Timeout: silent memory yields an error on the 4th WAIT cycle.
      step(vi(1, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0));
      step(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int k = 1; k <= 4; k++) begin
         cyc_a(idle_v());
         chk1("to_m0_resp_valid", m0_resp_valid, (k == 4));
         chk1("to_busy", busy, 1'b1);
         if (k == 4) begin
            chk1("to_m0_resp_err", m0_resp_err, 1'b1);
            chk32("to_m0_resp_rdata", m0_resp_rdata, 32'h0);
         end
         cyc_b(idle_v());
      end
      v = vi(0, 1, 0, 32'h90, 0, 0, 0, 1, 0, 0);
      cyc_a(v);
      chk1("to_next_m1_ready", m1_req_ready, 1'b1);
      chk1("to_next_busy", busy, 1'b0);
      cyc_b(v);
      step(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234));

      // Reset in the middle of WAIT, then a stale response.
      step(vi(0, 1, 0, 32'hC0, 0, 0, 0, 0, 0, 0));
      step(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(idle_v());
      m0_req_valid = 1'b1; m1_req_valid = 1'b1; mem_resp_valid = 1'b1;
      rst_n = 1'b0;
      #4;
      check_all_zero("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      cyc_a(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD));
      chk1("stale_m1_resp_valid", m1_resp_valid, 1'b0);
      cyc_b(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD));
      v = vi(1, 1, 32'hD0, 32'hE0, 0, 0, 0, 1, 0, 0);
      cyc_a(v);
      chk1("postrst_m0_ready", m0_req_ready, 1'b1);
      chk1("postrst_m1_ready", m1_req_ready, 1'b0);
      cyc_b(v);
      step(vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h600D));

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         v = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         v.m0v   = ($urandom_range(0, 1) == 1);
         v.m1v   = ($urandom_range(0, 1) == 1);
         v.a0    = $urandom;
         v.a1    = $urandom;
         v.we0   = ($urandom_range(0, 1) == 1);
         v.we1   = ($urandom_range(0, 1) == 1);
         v.wd    = $urandom;
         v.mrdy  = ($urandom_range(0, 9) < 6);
         v.mresp = ($urandom_range(0, 9) < 3);
         v.mrd   = $urandom;
         step(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
